// File: rtl/ex_issue_stage_if.sv
// Execute-stage operand interface: decoded ID fields and forwarding sources in,
// registered EX operands/controls and the load-use stall out.
interface ex_issue_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
);
  logic [REG_W-1:0]  IDRegA;
  logic [REG_W-1:0]  IDRegB;
  logic              IDUsesA;
  logic              IDUsesB;
  logic [DATA_W-1:0] IDDataA;
  logic [DATA_W-1:0] IDDataB;
  logic [REG_W-1:0]  IDRd;
  logic              IDRegWrite;
  logic              IDMemRead;
  logic              IDMemWrite;
  logic              IDFlagWrite;
  logic [1:0]        IDALUSrc;
  logic [2:0]        IDALUOp;
  logic [DATA_W-1:0] IDImm12Ext;
  logic [DATA_W-1:0] IDImm9Ext;
  logic              Flush;
  logic [DATA_W-1:0] EXALUOut;
  logic [DATA_W-1:0] MEMResult;
  logic [REG_W-1:0]  MEMRd;
  logic              MEMRegWrite;

  logic [DATA_W-1:0] EXDataA;
  logic [DATA_W-1:0] EXDataB;
  logic [DATA_W-1:0] EXImm12Ext;
  logic [DATA_W-1:0] EXImm9Ext;
  logic [1:0]        EXALUSrc;
  logic [2:0]        EXALUOp;
  logic              EXFlagWrite;
  logic              EXRegWrite;
  logic              EXMemRead;
  logic              EXMemWrite;
  logic [REG_W-1:0]  EXRd;
  logic              Stall;

  modport slave (
    input  IDRegA, IDRegB, IDUsesA, IDUsesB, IDDataA, IDDataB, IDRd,
           IDRegWrite, IDMemRead, IDMemWrite, IDFlagWrite, IDALUSrc, IDALUOp,
           IDImm12Ext, IDImm9Ext, Flush, EXALUOut, MEMResult, MEMRd, MEMRegWrite,
    output EXDataA, EXDataB, EXImm12Ext, EXImm9Ext, EXALUSrc, EXALUOp,
           EXFlagWrite, EXRegWrite, EXMemRead, EXMemWrite, EXRd, Stall
  );

  modport master (
    output IDRegA, IDRegB, IDUsesA, IDUsesB, IDDataA, IDDataB, IDRd,
           IDRegWrite, IDMemRead, IDMemWrite, IDFlagWrite, IDALUSrc, IDALUOp,
           IDImm12Ext, IDImm9Ext, Flush, EXALUOut, MEMResult, MEMRd, MEMRegWrite,
    input  EXDataA, EXDataB, EXImm12Ext, EXImm9Ext, EXALUSrc, EXALUOp,
           EXFlagWrite, EXRegWrite, EXMemRead, EXMemWrite, EXRd, Stall
  );
endinterface

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding and a one-cycle
// load-use stall; flushed or stalled slots issue as bubbles targeting XZR.
module ex_issue_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  ex_issue_stage_if.slave  bus
);
  localparam logic [REG_W-1:0] LP_ZERO = REG_W'(ZERO_REG);

  typedef enum logic {S_ISSUE, S_STALLED} state_t;

  state_t            r_state;
  logic              w_load_use;
  logic              w_stall;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // Load in EX whose destination is read by the ID instruction.
  always_comb begin
    w_load_use = 1'b0;
    w_stall    = 1'b0;
    if (bus.EXMemRead && (bus.EXRd != LP_ZERO)) begin
      w_load_use = (bus.IDUsesA && (bus.IDRegA == bus.EXRd)) ||
                   (bus.IDUsesB && (bus.IDRegB == bus.EXRd));
    end
    w_stall = w_load_use && !bus.Flush && (r_state == S_ISSUE);
  end

  // EX result beats MEM result; XZR always keeps the regfile value.
  always_comb begin
    w_fwd_a = bus.IDDataA;
    if (bus.IDRegA != LP_ZERO) begin
      if (bus.EXRegWrite && !bus.EXMemRead && (bus.EXRd == bus.IDRegA)) begin
        w_fwd_a = bus.EXALUOut;
      end else if (bus.MEMRegWrite && (bus.MEMRd == bus.IDRegA)) begin
        w_fwd_a = bus.MEMResult;
      end
    end
  end

  always_comb begin
    w_fwd_b = bus.IDDataB;
    if (bus.IDRegB != LP_ZERO) begin
      if (bus.EXRegWrite && !bus.EXMemRead && (bus.EXRd == bus.IDRegB)) begin
        w_fwd_b = bus.EXALUOut;
      end else if (bus.MEMRegWrite && (bus.MEMRd == bus.IDRegB)) begin
        w_fwd_b = bus.MEMResult;
      end
    end
  end

  assign bus.Stall = w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_ISSUE;
      bus.EXDataA     <= '0;
      bus.EXDataB     <= '0;
      bus.EXImm12Ext  <= '0;
      bus.EXImm9Ext   <= '0;
      bus.EXALUSrc    <= '0;
      bus.EXALUOp     <= '0;
      bus.EXFlagWrite <= 1'b0;
      bus.EXRegWrite  <= 1'b0;
      bus.EXMemRead   <= 1'b0;
      bus.EXMemWrite  <= 1'b0;
      bus.EXRd        <= '0;
    end else if (bus.Flush || w_stall) begin
      // Bubble; a stall holds the ID instruction for exactly one cycle.
      r_state         <= bus.Flush ? S_ISSUE : S_STALLED;
      bus.EXDataA     <= '0;
      bus.EXDataB     <= '0;
      bus.EXImm12Ext  <= '0;
      bus.EXImm9Ext   <= '0;
      bus.EXALUSrc    <= '0;
      bus.EXALUOp     <= '0;
      bus.EXFlagWrite <= 1'b0;
      bus.EXRegWrite  <= 1'b0;
      bus.EXMemRead   <= 1'b0;
      bus.EXMemWrite  <= 1'b0;
      bus.EXRd        <= LP_ZERO;
    end else begin
      r_state         <= S_ISSUE;
      bus.EXDataA     <= w_fwd_a;
      bus.EXDataB     <= w_fwd_b;
      bus.EXImm12Ext  <= bus.IDImm12Ext;
      bus.EXImm9Ext   <= bus.IDImm9Ext;
      bus.EXALUSrc    <= bus.IDALUSrc;
      bus.EXALUOp     <= bus.IDALUOp;
      bus.EXFlagWrite <= bus.IDFlagWrite;
      bus.EXRegWrite  <= bus.IDRegWrite;
      bus.EXMemRead   <= bus.IDMemRead;
      bus.EXMemWrite  <= bus.IDMemWrite;
      bus.EXRd        <= bus.IDRd;
    end
  end
endmodule
